// File: rtl/tl_d_pkg.sv
// Shared TileLink D-channel definitions: opcodes, default geometry and a
// helper that turns a message size into a beat count.
package tl_d_pkg;

  localparam int unsigned DEF_DATA_W      = 64;
  localparam int unsigned DEF_BLOCK_BYTES = 64;
  localparam int unsigned DEF_SOURCE_W    = 3;
  localparam int unsigned DEF_SINK_W      = 3;
  localparam int unsigned DEF_SET_W       = 10;
  localparam int unsigned DEF_WAY_W       = 3;

  // Beat-index width for the default geometry (8 beats per block).
  localparam int unsigned BEAT_W = $clog2(DEF_BLOCK_BYTES / (DEF_DATA_W / 8));

  localparam logic [2:0] OP_GRANT       = 3'd4;
  localparam logic [2:0] OP_GRANT_DATA  = 3'd5;
  localparam logic [2:0] OP_RELEASE_ACK = 3'd6;

  // Beats in a message: data messages span 2^size bytes (at least one beat),
  // everything else is a single beat. Clamped so a bad size cannot overflow.
  function automatic int unsigned beats_from_size(
    input logic [2:0]  size,
    input logic        has_data,
    input int unsigned lg_beat_bytes,
    input int unsigned max_beats
  );
    int unsigned beats;
    if (!has_data || (32'(size) <= lg_beat_bytes)) begin
      beats = 32'd1;
    end else begin
      beats = 32'd1 << (32'(size) - lg_beat_bytes);
    end
    if (beats > max_beats) begin
      beats = max_beats;
    end
    return beats;
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Beat counter for multi-beat TileLink messages.
// Ports: clock/reset; i_fire advances on an accepted beat; i_opcode/i_size
// describe the current beat; o_first_c/o_last_c flag message boundaries
// (combinational from the count); o_count is the registered beat index.
module tl_beat_counter
  import tl_d_pkg::*;
#(
  parameter int unsigned CNT_W         = BEAT_W,
  parameter int unsigned LG_BEAT_BYTES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_fire,
  input  logic [2:0]       i_opcode,
  input  logic [2:0]       i_size,
  output logic             o_first_c,
  output logic             o_last_c,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned MAX_BEATS = 32'd1 << CNT_W;

  logic             w_has_data;
  logic [CNT_W-1:0] w_last_idx;

  assign w_has_data = i_opcode[0];

  // Index of the final beat of the message currently on the bus.
  always_comb begin
    w_last_idx = CNT_W'(beats_from_size(i_size, w_has_data, LG_BEAT_BYTES, MAX_BEATS) - 32'd1);
  end

  assign o_first_c = (o_count == '0);
  assign o_last_c  = (o_count == w_last_idx) || !w_has_data;

  // Advance on every accepted beat, wrap to zero after the last one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_count <= '0;
    end else if (i_fire) begin
      o_count <= o_last_c ? '0 : o_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sink_d.sv
// Outer-side D-channel receiver for the inclusive cache.
// Accepts Grant/GrantData/ReleaseAck beats, pulses first/last responses to
// the MSHR scheduler, looks up way/set via io_source and writes GrantData
// beats into the banked store (address this cycle, data one cycle later).
// Ports: io_d_* D channel in; io_resp_* scheduler response; io_source/io_way/
// io_set MSHR lookup; io_bs_adr_* store address; io_bs_dat_* store data.
module sink_d
  import tl_d_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int unsigned SOURCE_W    = DEF_SOURCE_W,
  parameter int unsigned SINK_W      = DEF_SINK_W,
  parameter int unsigned SET_W       = DEF_SET_W,
  parameter int unsigned WAY_W       = DEF_WAY_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_d_valid,
  output logic                io_d_ready,
  input  logic [2:0]          io_d_bits_opcode,
  input  logic [2:0]          io_d_bits_param,
  input  logic [2:0]          io_d_bits_size,
  input  logic [SOURCE_W-1:0] io_d_bits_source,
  input  logic [SINK_W-1:0]   io_d_bits_sink,
  input  logic                io_d_bits_denied,
  input  logic [DATA_W-1:0]   io_d_bits_data,
  input  logic                io_d_bits_corrupt,
  output logic                io_resp_valid,
  output logic                io_resp_bits_last,
  output logic [2:0]          io_resp_bits_opcode,
  output logic [2:0]          io_resp_bits_param,
  output logic [SOURCE_W-1:0] io_resp_bits_source,
  output logic [SINK_W-1:0]   io_resp_bits_sink,
  output logic                io_resp_bits_denied,
  output logic [SOURCE_W-1:0] io_source,
  input  logic [WAY_W-1:0]    io_way,
  input  logic [SET_W-1:0]    io_set,
  output logic                io_bs_adr_valid,
  input  logic                io_bs_adr_ready,
  output logic                io_bs_adr_bits_noop,
  output logic [WAY_W-1:0]    io_bs_adr_bits_way,
  output logic [SET_W-1:0]    io_bs_adr_bits_set,
  output logic [BEAT_W-1:0]   io_bs_adr_bits_beat,
  output logic [DATA_W-1:0]   io_bs_dat_data,
  output logic                io_bs_dat_corrupt
);

  localparam int unsigned LG_BLOCK      = $clog2(BLOCK_BYTES);
  localparam int unsigned LG_BEAT_BYTES = $clog2(DATA_W / 8);
  localparam int unsigned CNT_W         = LG_BLOCK - LG_BEAT_BYTES;

  logic                w_has_data;
  logic                w_fire;
  logic                w_first;
  logic                w_last;
  logic [CNT_W-1:0]    w_count;

  logic [SOURCE_W-1:0] r_source;
  logic [2:0]          r_opcode;
  logic [DATA_W-1:0]   r_data;
  logic                r_corrupt;
  logic                r_dat_valid;

  assign w_has_data = io_d_bits_opcode[0];

  // Only data beats need a store slot; acks and Grants are always accepted.
  assign io_d_ready = !w_has_data || io_bs_adr_ready;
  assign w_fire     = io_d_valid && io_d_ready;

  tl_beat_counter #(
    .CNT_W         (CNT_W),
    .LG_BEAT_BYTES (LG_BEAT_BYTES)
  ) u_beat_counter (
    .clock     (clock),
    .reset     (reset),
    .i_fire    (w_fire),
    .i_opcode  (io_d_bits_opcode),
    .i_size    (io_d_bits_size),
    .o_first_c (w_first),
    .o_last_c  (w_last),
    .o_count   (w_count)
  );

  // Remember the owning MSHR (and opcode) for the rest of the burst.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_source <= '0;
      r_opcode <= '0;
    end else if (w_fire && w_first) begin
      r_source <= io_d_bits_source;
      r_opcode <= io_d_bits_opcode;
    end
  end

  assign io_source = w_first ? io_d_bits_source : r_source;

  // Address phase: lookup result plus the current beat index.
  assign io_bs_adr_valid     = io_d_valid && w_has_data;
  assign io_bs_adr_bits_noop = io_d_bits_denied;
  assign io_bs_adr_bits_way  = io_way;
  assign io_bs_adr_bits_set  = io_set;
  assign io_bs_adr_bits_beat = BEAT_W'(w_count);

  // Data phase: capture on a data fire, present the following cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data      <= '0;
      r_corrupt   <= 1'b0;
      r_dat_valid <= 1'b0;
    end else if (w_fire && w_has_data) begin
      r_data      <= io_d_bits_data;
      r_corrupt   <= io_d_bits_corrupt;
      r_dat_valid <= 1'b1;
    end
  end

  assign io_bs_dat_data    = r_dat_valid ? r_data : '0;
  assign io_bs_dat_corrupt = r_dat_valid && r_corrupt;

  // Scheduler only hears about the first and last beat of each message.
  assign io_resp_valid       = w_fire && (w_first || w_last);
  assign io_resp_bits_last   = w_last;
  assign io_resp_bits_opcode = io_d_bits_opcode;
  assign io_resp_bits_param  = io_d_bits_param;
  assign io_resp_bits_source = io_d_bits_source;
  assign io_resp_bits_sink   = io_d_bits_sink;
  assign io_resp_bits_denied = io_d_bits_denied;

`ifndef SYNTHESIS
  // Protocol checks on the incoming stream.
  always @(posedge clock) begin
    if (!reset && io_d_valid) begin
      assert (32'(io_d_bits_size) <= LG_BLOCK)
        else $error("sink_d: D size %0d exceeds block", io_d_bits_size);
    end
    if (!reset && w_fire && !w_first) begin
      assert ((io_d_bits_source == r_source) && (io_d_bits_opcode == r_opcode))
        else $error("sink_d: source/opcode changed mid-burst");
    end
  end
`endif

endmodule

// File: tb/tb_sink_d.sv
// Randomized self-checking bench for sink_d.
module tb_sink_d;

  logic        clock;
  logic        reset;
  logic        io_d_valid;
  logic        io_d_ready;
  logic [2:0]  io_d_bits_opcode;
  logic [2:0]  io_d_bits_param;
  logic [2:0]  io_d_bits_size;
  logic [2:0]  io_d_bits_source;
  logic [2:0]  io_d_bits_sink;
  logic        io_d_bits_denied;
  logic [63:0] io_d_bits_data;
  logic        io_d_bits_corrupt;
  logic        io_resp_valid;
  logic        io_resp_bits_last;
  logic [2:0]  io_resp_bits_opcode;
  logic [2:0]  io_resp_bits_param;
  logic [2:0]  io_resp_bits_source;
  logic [2:0]  io_resp_bits_sink;
  logic        io_resp_bits_denied;
  logic [2:0]  io_source;
  logic [2:0]  io_way;
  logic [9:0]  io_set;
  logic        io_bs_adr_valid;
  logic        io_bs_adr_ready;
  logic        io_bs_adr_bits_noop;
  logic [2:0]  io_bs_adr_bits_way;
  logic [9:0]  io_bs_adr_bits_set;
  logic [2:0]  io_bs_adr_bits_beat;
  logic [63:0] io_bs_dat_data;
  logic        io_bs_dat_corrupt;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0]  way_tab [8];
  logic [9:0]  set_tab [8];
  logic [63:0] exp_dat;
  logic        exp_crp;
  int          wr_exp;
  int          wr_act;

  sink_d dut (
    .clock               (clock),
    .reset               (reset),
    .io_d_valid          (io_d_valid),
    .io_d_ready          (io_d_ready),
    .io_d_bits_opcode    (io_d_bits_opcode),
    .io_d_bits_param     (io_d_bits_param),
    .io_d_bits_size      (io_d_bits_size),
    .io_d_bits_source    (io_d_bits_source),
    .io_d_bits_sink      (io_d_bits_sink),
    .io_d_bits_denied    (io_d_bits_denied),
    .io_d_bits_data      (io_d_bits_data),
    .io_d_bits_corrupt   (io_d_bits_corrupt),
    .io_resp_valid       (io_resp_valid),
    .io_resp_bits_last   (io_resp_bits_last),
    .io_resp_bits_opcode (io_resp_bits_opcode),
    .io_resp_bits_param  (io_resp_bits_param),
    .io_resp_bits_source (io_resp_bits_source),
    .io_resp_bits_sink   (io_resp_bits_sink),
    .io_resp_bits_denied (io_resp_bits_denied),
    .io_source           (io_source),
    .io_way              (io_way),
    .io_set              (io_set),
    .io_bs_adr_valid     (io_bs_adr_valid),
    .io_bs_adr_ready     (io_bs_adr_ready),
    .io_bs_adr_bits_noop (io_bs_adr_bits_noop),
    .io_bs_adr_bits_way  (io_bs_adr_bits_way),
    .io_bs_adr_bits_set  (io_bs_adr_bits_set),
    .io_bs_adr_bits_beat (io_bs_adr_bits_beat),
    .io_bs_dat_data      (io_bs_dat_data),
    .io_bs_dat_corrupt   (io_bs_dat_corrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // MSHR lookup table model: way/set owned by each source id.
  always_comb begin
    io_way = way_tab[io_source];
    io_set = set_tab[io_source];
  end

  // Count store address handshakes actually taken.
  always @(posedge clock) begin
    if (!reset && io_bs_adr_valid && io_bs_adr_ready) wr_act <= wr_act + 1;
  end

  // Send one message (or its first max_fire beats), checking every beat
  // against the message-level expectations computed from size/opcode.
  task automatic drive_msg(input logic [2:0] op, input logic [2:0] sz,
                           input logic [2:0] src, input logic den,
                           input int stall_at, input int stall_len,
                           input int max_fire);
    int          nb;
    logic        hd;
    logic [63:0] dat;
    logic        crp;
    logic [2:0]  prm;
    logic [2:0]  snk;
    bit          fst;
    bit          lst;
    hd  = op[0];
    nb  = (hd && ((1 << sz) / 8) > 1) ? ((1 << sz) / 8) : 1;
    prm = 3'($urandom_range(0, 7));
    snk = 3'($urandom_range(0, 7));
    for (int i = 0; i < nb && i < max_fire; i++) begin
      @(negedge clock);
      dat = {$urandom, $urandom};
      crp = 1'($urandom_range(0, 1));
      io_d_valid        = 1'b1;
      io_d_bits_opcode  = op;
      io_d_bits_param   = prm;
      io_d_bits_size    = sz;
      io_d_bits_source  = src;
      io_d_bits_sink    = snk;
      io_d_bits_denied  = den;
      io_d_bits_data    = dat;
      io_d_bits_corrupt = crp;
      if (hd && i == stall_at) begin
        io_bs_adr_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          #1;
          n_vec++;
          if (io_d_ready !== 1'b0 || io_resp_valid !== 1'b0 || io_bs_adr_bits_beat !== 3'(i)) begin
            n_err++;
            $display("FAIL stall beat %0d: ready=%b resp=%b beat=%0d, want ready=0 resp=0 beat=%0d",
                     i, io_d_ready, io_resp_valid, io_bs_adr_bits_beat, i);
          end
          @(negedge clock);
        end
        io_bs_adr_ready = 1'b1;
      end
      #1;
      fst = (i == 0);
      lst = (i == nb - 1);
      n_vec++;
      if (io_d_ready !== 1'b1 || io_source !== src || io_bs_adr_valid !== hd) begin
        n_err++;
        $display("FAIL beat %0d src: ready=%b source=%0d adr_valid=%b, want 1 %0d %b",
                 i, io_d_ready, io_source, io_bs_adr_valid, src, hd);
      end
      if (hd) begin
        n_vec++;
        wr_exp++;
        if (io_bs_adr_bits_beat !== 3'(i) || io_bs_adr_bits_noop !== den ||
            io_bs_adr_bits_way !== way_tab[src] || io_bs_adr_bits_set !== set_tab[src]) begin
          n_err++;
          $display("FAIL adr beat %0d: beat=%0d noop=%b way=%0d set=%0d, want %0d %b %0d %0d",
                   i, io_bs_adr_bits_beat, io_bs_adr_bits_noop, io_bs_adr_bits_way,
                   io_bs_adr_bits_set, i, den, way_tab[src], set_tab[src]);
        end
      end
      n_vec++;
      if (io_resp_valid !== (fst || lst)) begin
        n_err++;
        $display("FAIL resp_valid beat %0d: got %b want %b", i, io_resp_valid, (fst || lst));
      end
      if (fst || lst) begin
        n_vec++;
        if (io_resp_bits_last !== lst || io_resp_bits_opcode !== op || io_resp_bits_param !== prm ||
            io_resp_bits_source !== src || io_resp_bits_sink !== snk || io_resp_bits_denied !== den) begin
          n_err++;
          $display("FAIL resp bits beat %0d: last=%b op=%0d param=%0d src=%0d sink=%0d den=%b, want %b %0d %0d %0d %0d %b",
                   i, io_resp_bits_last, io_resp_bits_opcode, io_resp_bits_param, io_resp_bits_source,
                   io_resp_bits_sink, io_resp_bits_denied, lst, op, prm, src, snk, den);
        end
      end
      @(posedge clock);
      #1;
      if (hd) begin
        exp_dat = dat;
        exp_crp = crp;
      end
      n_vec++;
      if (io_bs_dat_data !== exp_dat || io_bs_dat_corrupt !== exp_crp) begin
        n_err++;
        $display("FAIL bs_dat beat %0d: data=%h corrupt=%b, want %h %b",
                 i, io_bs_dat_data, io_bs_dat_corrupt, exp_dat, exp_crp);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      io_d_valid = 1'b0;
      #1;
      n_vec++;
      if (io_resp_valid !== 1'b0 || io_bs_adr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle: resp=%b adr_valid=%b, want 0 0", io_resp_valid, io_bs_adr_valid);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_d_valid = 1'b0;
    io_d_bits_opcode = 3'd5;
    io_d_bits_param = '0;
    io_d_bits_size = '0;
    io_d_bits_source = '0;
    io_d_bits_sink = '0;
    io_d_bits_denied = 1'b0;
    io_d_bits_data = '0;
    io_d_bits_corrupt = 1'b0;
    io_bs_adr_ready = 1'b0;
    exp_dat = '0;
    exp_crp = 1'b0;
    wr_exp = 0;
    wr_act = 0;
    #1;
    n_vec++;
    if (io_d_ready !== 1'b0 || io_resp_valid !== 1'b0 || io_bs_adr_valid !== 1'b0 ||
        io_bs_dat_data !== 64'd0 || io_bs_dat_corrupt !== 1'b0 || io_source !== 3'd0 ||
        io_bs_adr_bits_beat !== 3'd0) begin
      n_err++;
      $display("FAIL reset state: ready=%b resp=%b adr=%b dat=%h crp=%b src=%0d beat=%0d, want all 0",
               io_d_ready, io_resp_valid, io_bs_adr_valid, io_bs_dat_data, io_bs_dat_corrupt,
               io_source, io_bs_adr_bits_beat);
    end
    io_bs_adr_ready = 1'b1;
    #1;
    n_vec++;
    if (io_d_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset ready follow: got %b want 1", io_d_ready);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_grant_data();
    drive_msg(3'd5, 3'd6, 3'd2, 1'b0, -1, 0, 8);
    idle(1);
  endtask

  task automatic test_grant();
    io_bs_adr_ready = 1'b0;
    drive_msg(3'd4, 3'd6, 3'd3, 1'b0, -1, 0, 8);
    io_bs_adr_ready = 1'b1;
    idle(1);
    n_vec++;
    if (io_bs_adr_bits_beat !== 3'd0) begin
      n_err++;
      $display("FAIL grant counter: beat=%0d want 0", io_bs_adr_bits_beat);
    end
    drive_msg(3'd6, 3'd0, 3'd6, 1'b0, -1, 0, 8);
    idle(1);
  endtask

  task automatic test_stall();
    wr_exp = 0;
    @(negedge clock);
    wr_act = 0;
    drive_msg(3'd5, 3'd6, 3'd4, 1'b0, 4, 3, 8);
    idle(1);
    n_vec++;
    if (wr_act !== wr_exp || wr_exp !== 8) begin
      n_err++;
      $display("FAIL stall writes: got %0d want %0d", wr_act, 8);
    end
  endtask

  task automatic test_denied();
    drive_msg(3'd5, 3'd6, 3'd7, 1'b1, -1, 0, 8);
    idle(1);
  endtask

  task automatic test_back_to_back();
    drive_msg(3'd5, 3'd6, 3'd1, 1'b0, -1, 0, 8);
    drive_msg(3'd5, 3'd6, 3'd5, 1'b0, -1, 0, 8);
    idle(1);
  endtask

  task automatic test_reset_mid_burst();
    drive_msg(3'd5, 3'd6, 3'd3, 1'b0, -1, 0, 3);
    @(negedge clock);
    io_d_valid = 1'b0;
    reset = 1'b1;
    exp_dat = '0;
    exp_crp = 1'b0;
    #1;
    n_vec++;
    if (io_bs_adr_bits_beat !== 3'd0 || io_bs_dat_data !== 64'd0 || io_resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid-burst reset: beat=%0d dat=%h resp=%b, want 0 0 0",
               io_bs_adr_bits_beat, io_bs_dat_data, io_resp_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    drive_msg(3'd5, 3'd6, 3'd4, 1'b0, -1, 0, 8);
    idle(1);
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [2:0] sz;
    for (int m = 0; m < 40; m++) begin
      case ($urandom_range(0, 2))
        0:       op = 3'd4;
        1:       op = 3'd5;
        default: op = 3'd6;
      endcase
      sz = 3'($urandom_range(0, 6));
      drive_msg(op, sz, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7), $urandom_range(0, 2), 8);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int s = 0; s < 8; s++) begin
      way_tab[s] = 3'($urandom_range(0, 7));
      set_tab[s] = 10'($urandom_range(0, 1023));
    end
    test_reset();
    test_grant_data();
    test_grant();
    test_stall();
    test_denied();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sink_d.md
Name: sink_d

Overview:
- Inclusive-cache outer-side D-channel receiver. It sits downstream of the cache's A-channel request issuer, which sends AcquireBlock/AcquirePerm to the outer memory system.
- Accepts TileLink Grant, GrantData and ReleaseAck beats from the outer system.
- Reports first/last-beat responses to the MSHR scheduler.
- Writes GrantData beats into the banked data store, using way/set looked up from the owning MSHR.

Parameters:
- DATA_W, 64, D-channel data width in bits (8 bytes per beat).
- BLOCK_BYTES, 64, cache block size; 8 beats per block at default.
- SOURCE_W, 3, outer source-id width (MSHR index).
- SINK_W, 3, outer sink-id width.
- SET_W, 10, set index width.
- WAY_W, 3, way index width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- io_d_valid  in  1  D beat valid.
- io_d_ready  out  1  D beat accepted.
- io_d_bits_opcode  in  3  4=Grant, 5=GrantData, 6=ReleaseAck.
- io_d_bits_param  in  3  cap param.
- io_d_bits_size  in  3  log2 bytes.
- io_d_bits_source  in  SOURCE_W  MSHR id.
- io_d_bits_sink  in  SINK_W  outer sink id.
- io_d_bits_denied  in  1  denied.
- io_d_bits_data  in  DATA_W  beat data.
- io_d_bits_corrupt  in  1  corrupt (forwarded in data phase).
- io_resp_valid  out  1  response pulse to scheduler (no backpressure).
- io_resp_bits_last  out  1  response marks last beat.
- io_resp_bits_opcode  out  3.
- io_resp_bits_param  out  3.
- io_resp_bits_source  out  SOURCE_W.
- io_resp_bits_sink  out  SINK_W.
- io_resp_bits_denied  out  1.
- io_source  out  SOURCE_W  MSHR lookup index.
- io_way  in  WAY_W  combinational lookup result for io_source.
- io_set  in  SET_W  combinational lookup result for io_source.
- io_bs_adr_valid  out  1  banked-store write address valid.
- io_bs_adr_ready  in  1  banked-store can accept.
- io_bs_adr_bits_noop  out  1  write suppressed (denied).
- io_bs_adr_bits_way  out  WAY_W.
- io_bs_adr_bits_set  out  SET_W.
- io_bs_adr_bits_beat  out  3  beat index.
- io_bs_dat_data  out  DATA_W  write data, one cycle after address.
- io_bs_dat_corrupt  out  1.

Behaviour:
- Reset (async, active-high) clears: beat counter, latched source, data register, data-phase valid. All outputs read 0 out of reset; io_d_ready follows combinationally from io_bs_adr_ready.
- hasData = opcode[0] (GrantData only).
- beats = hasData ? max(1, 2^size/8) : 1.
- Beat counter runs 0..beats-1, advances on d fire (valid && ready), wraps to 0 after the last beat.
  - first = (counter == 0).
  - last = (counter == beats-1) || !hasData.
- io_source = first ? io_d_bits_source : latched source. The source latches on the first-beat fire.
- Address phase:
  - io_bs_adr_valid = io_d_valid && hasData.
  - way/set come from the lookup; beat = counter.
  - noop = denied.
- io_d_ready = !hasData || io_bs_adr_ready. Non-data beats never stall.
- Data phase: on a GrantData fire, register data/corrupt. io_bs_dat_* presents it exactly 1 cycle later, held until the next fire.
- Response:
  - io_resp_valid = d fire && (first || last), combinational, same cycle as the fire.
  - resp_bits_last = last.
  - Remaining resp fields mirror the D beat.
  - A single-beat message pulses once with last=1.
- Burst rules:
  - Beats of a burst must share source/opcode; a mismatch triggers a simulation assertion.
  - size > log2(BLOCK_BYTES) triggers an assertion.
- Stalls: io_bs_adr_ready low mid-burst holds the counter and keeps io_d_ready low. No beat is lost or duplicated.
- Reset mid-burst: counter returns to 0; the next accepted beat is treated as first.

Decomposition:
- Shared package tl_d_pkg:
  - opcode constants GRANT=4, GRANT_DATA=5, RELEASE_ACK=6;
  - BEAT_W = log2(BLOCK_BYTES/(DATA_W/8));
  - beats-from-size function.
- One natural sub-module, tl_beat_counter: size/opcode in, first/last/count out, advance on fire. Reusable by the other D/C-channel sinks.

Test Plan:
- GrantData, size=6, source=2, bs ready always:
  - 8 fires on consecutive cycles, beats 0..7;
  - resp pulses on beat 0 (last=0) and beat 7 (last=1);
  - bs data equals each beat's data 1 cycle after its address.
- Grant, size=6, denied=0: single fire; resp pulse last=1; io_bs_adr_valid stays 0; counter stays 0.
- GrantData with io_bs_adr_ready low for 3 cycles at beat 4: io_d_ready low 3 cycles; beat 4 is written once; resp last still on beat 7.
- GrantData with denied=1: all 8 bs addresses carry noop=1; resp denied=1 on first and last.
- Back-to-back GrantData source=1 then source=5: io_source shows 1 for beats 0..7, then 5 from the next first beat; counter wraps 7→0 with no idle cycle.
- Reset asserted at beat 3 of a burst, released, new GrantData sent: counter restarts at 0; first resp has last=0; no stale data-phase write.
